ifmap_fifo_feeder: RTL and testbench
====================================

IFMAP_FIFO_FEEDER -- requirements
Module: ifmap_fifo_feeder

Interface
REQ-001 Parameter: ADDR_W, 32, GLB byte-address width.
REQ-002 Parameter: CNT_W, 16, width of word-count field.
REQ-003 clk  in  1  clock; all state updates on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 start_i  in  1  one-cycle job launch; sampled only in IDLE.
REQ-006 base_addr_i  in  ADDR_W  GLB byte address of first word; latched on start.
REQ-007 word_cnt_i  in  CNT_W  number of 32-bit words to transfer; latched on start.
REQ-008 pad_front_i / pad_back_i  in  2 each  zero bytes pushed before / after words; latched on start.
REQ-009 flush_i  in  1  abort current job and clear downstream FIFO.
REQ-010 busy_o  out  1  high from start acceptance until done/flush.
REQ-011 done_o  out  1  one-cycle pulse when job completes.
REQ-012 glb_req_o  out  1  GLB read request.
REQ-013 glb_addr_o  out  ADDR_W  GLB read address.
REQ-014 glb_gnt_i  in  1  request accepted this cycle.
REQ-015 glb_rvalid_i / glb_rdata_i  in  1 / 32  read data return.
REQ-016 fifo_push_en_o, fifo_push_mod_o  out  1 each  push strobe; mod 0 = byte, 1 = 4-byte burst.
REQ-017 fifo_push_data_o  out  32  push payload; byte push uses [7:0].
REQ-018 fifo_full_i, fifo_empty_i  in  1 each  downstream FIFO flags.
REQ-019 fifo_reset_o  out  1  synchronous clear to downstream FIFO.

Function
REQ-020 FSM states SHALL be IDLE, PAD_F, FETCH, WAIT_R, PUSH, PAD_B, DONE.
REQ-021 IDLE + start_i: latch job fields, addr_q=base_addr_i, rem_q=word_cnt_i; go PAD_F if pad_front>0, else FETCH if rem>0, else PAD_B if pad_back>0, else DONE.
REQ-022 PAD_F/PAD_B: each cycle with fifo_full_i=0, drive push_en=1, mod=0, data=0 and decrement pad counter; hold push_en=0 while full.
REQ-023 FETCH: glb_req_o=1, glb_addr_o=addr_q held stable until glb_gnt_i=1; on grant go WAIT_R and addr_q+=4.
REQ-024 WAIT_R: on glb_rvalid_i capture glb_rdata_i into hold_q, go PUSH; one read outstanding at most.
REQ-025 PUSH: push_en=1, mod=1, data=hold_q only in cycles with fifo_empty_i=1 (burst accepted only when FIFO empty); on that cycle rem_q-=1, go FETCH if rem_q>1, else PAD_B if pad_back>0, else DONE.
REQ-026 Bytes of hold_q SHALL reach FIFO unchanged: [7:0] popped first, [31:24] last.
REQ-027 DONE: done_o=1 one cycle, busy_o=0 next cycle, return to IDLE.
REQ-028 push_en_o SHALL never be high with mod=0 and fifo_full_i=1, nor with mod=1 and fifo_empty_i=0.
REQ-029 flush_i in any state: fifo_reset_o=1 that cycle, push_en=0, glb_req_o=0, next state IDLE, no done_o; if a read was granted and not returned, set drop_q so the next glb_rvalid_i is discarded.
REQ-030 glb_rvalid_i outside WAIT_R (or while drop_q=1) SHALL be ignored; drop_q clears on that rvalid.
REQ-031 start_i while busy_o=1 SHALL be ignored; flush_i and start_i same cycle: flush wins.
REQ-032 addr_q SHALL wrap modulo 2^ADDR_W; word_cnt_i=0 with no pads completes in 2 cycles (start -> DONE -> IDLE).

Reset
REQ-033 rst_n low: state IDLE, all counters/hold_q/addr_q/drop_q zero; busy_o, done_o, glb_req_o, fifo_push_en_o, fifo_push_mod_o, fifo_reset_o = 0; glb_addr_o, fifo_push_data_o = 0.
REQ-034 Reset deassertion SHALL not generate any push, request or done pulse.

Verification
REQ-035 base=0x100, cnt=2, pads 0, gnt immediate, rvalid 1 cycle later, FIFO drained each time -> addr 0x100 then 0x104, two burst pushes with exact data, done_o one pulse.
REQ-036 pad_front=2, cnt=1, pad_back=1 -> byte pushes 0,0, burst word, byte 0 in order; no burst while FIFO holds pad bytes.
REQ-037 FIFO held non-empty 10 cycles in PUSH -> push_en stays 0, hold_q stable, push occurs first cycle empty=1.
REQ-038 flush_i in WAIT_R, then late rvalid, then new job base=0x200 -> fifo_reset_o pulse, stale data never pushed, new job data correct.
REQ-039 glb_gnt_i delayed 5 cycles -> glb_req_o and glb_addr_o stable throughout; start_i during busy ignored.
REQ-040 rst_n asserted mid-PUSH -> all outputs zero immediately; cnt=0, no pads -> done_o exactly 1 cycle after start.

Source files
------------

// File: rtl/ifmap_fifo_feeder.sv
// Input-feature-map feeder: reads words from the GLB and pushes optional zero
// padding plus 4-byte bursts into the downstream byte FIFO.
//
//   state  | meaning
//   IDLE   | waiting for start_i
//   PAD_F  | pushing front zero bytes
//   FETCH  | GLB read request held until granted
//   WAIT_R | one read outstanding, waiting for rvalid
//   PUSH   | burst push of hold_q, only into an empty FIFO
//   PAD_B  | pushing back zero bytes
//   DONE   | one-cycle completion pulse
module ifmap_fifo_feeder #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic [CNT_W-1:0]  word_cnt_i,
  input  logic [1:0]        pad_front_i,
  input  logic [1:0]        pad_back_i,
  input  logic              flush_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              glb_req_o,
  output logic [ADDR_W-1:0] glb_addr_o,
  input  logic              glb_gnt_i,
  input  logic              glb_rvalid_i,
  input  logic [31:0]       glb_rdata_i,
  output logic              fifo_push_en_o,
  output logic              fifo_push_mod_o,
  output logic [31:0]       fifo_push_data_o,
  input  logic              fifo_full_i,
  input  logic              fifo_empty_i,
  output logic              fifo_reset_o
);

  typedef enum logic [2:0] {IDLE, PAD_F, FETCH, WAIT_R, PUSH, PAD_B, DONE} state_t;

  state_t            state;
  logic [ADDR_W-1:0] addr_q;
  logic [CNT_W-1:0]  rem_q;
  logic [1:0]        pf_q;
  logic [1:0]        pb_q;
  logic [31:0]       hold_q;
  logic              drop_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      addr_q <= '0;
      rem_q  <= '0;
      pf_q   <= '0;
      pb_q   <= '0;
      hold_q <= '0;
      drop_q <= 1'b0;
    end else if (flush_i) begin
      state <= IDLE;
      // our own read is still in flight unless it returns in this very cycle
      if (state == WAIT_R && !glb_rvalid_i) drop_q <= 1'b1;
      else if (glb_rvalid_i)                drop_q <= 1'b0;
    end else begin
      if (glb_rvalid_i && drop_q) drop_q <= 1'b0;
      case (state)
        IDLE: if (start_i) begin
          addr_q <= base_addr_i;
          rem_q  <= word_cnt_i;
          pf_q   <= pad_front_i;
          pb_q   <= pad_back_i;
          if (pad_front_i != 2'd0)     state <= PAD_F;
          else if (word_cnt_i != '0)   state <= FETCH;
          else if (pad_back_i != 2'd0) state <= PAD_B;
          else                         state <= DONE;
        end
        PAD_F: if (!fifo_full_i) begin
          pf_q <= pf_q - 2'd1;
          if (pf_q == 2'd1) begin
            if (rem_q != '0)       state <= FETCH;
            else if (pb_q != 2'd0) state <= PAD_B;
            else                   state <= DONE;
          end
        end
        FETCH: if (glb_gnt_i && !drop_q) begin
          addr_q <= addr_q + ADDR_W'(4);
          state  <= WAIT_R;
        end
        WAIT_R: if (glb_rvalid_i && !drop_q) begin
          hold_q <= glb_rdata_i;
          state  <= PUSH;
        end
        PUSH: if (fifo_empty_i) begin
          rem_q <= rem_q - CNT_W'(1);
          if (rem_q > CNT_W'(1)) state <= FETCH;
          else if (pb_q != 2'd0) state <= PAD_B;
          else                   state <= DONE;
        end
        PAD_B: if (!fifo_full_i) begin
          pb_q <= pb_q - 2'd1;
          if (pb_q == 2'd1) state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Push and request strobes must react to the FIFO flags and flush in the same cycle.
  assign busy_o           = (state != IDLE);
  assign done_o           = (state == DONE) && !flush_i;
  // a stale read still in flight blocks new requests, keeping one outstanding at most
  assign glb_req_o        = (state == FETCH) && !drop_q && !flush_i;
  assign glb_addr_o       = addr_q;
  assign fifo_push_mod_o  = (state == PUSH);
  assign fifo_push_data_o = (state == PUSH) ? hold_q : 32'd0;
  assign fifo_push_en_o   = !flush_i &&
                            ((((state == PAD_F) || (state == PAD_B)) && !fifo_full_i) ||
                             ((state == PUSH) && fifo_empty_i));
  assign fifo_reset_o     = flush_i && rst_n;

endmodule

// File: tb/tb_ifmap_fifo_feeder.sv
// Directed plus randomized bench for ifmap_fifo_feeder with a GLB responder,
// a byte-count FIFO model and an expected byte stream built from each job.
module tb_ifmap_fifo_feeder;
  localparam int CAP = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_i = 1'b0, flush_i = 1'b0;
  logic [31:0] base_addr_i = '0;
  logic [15:0] word_cnt_i = '0;
  logic [1:0]  pad_front_i = '0, pad_back_i = '0;
  logic        busy_o, done_o, glb_req_o, fifo_push_en_o, fifo_push_mod_o, fifo_reset_o;
  logic [31:0] glb_addr_o, fifo_push_data_o;
  logic        glb_gnt_i = 1'b0, glb_rvalid_i = 1'b0;
  logic [31:0] glb_rdata_i = '0;
  logic        fifo_full_i = 1'b0, fifo_empty_i = 1'b1;

  always #5 clk = ~clk;

  ifmap_fifo_feeder #(.ADDR_W(32), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .base_addr_i(base_addr_i),
    .word_cnt_i(word_cnt_i), .pad_front_i(pad_front_i), .pad_back_i(pad_back_i),
    .flush_i(flush_i), .busy_o(busy_o), .done_o(done_o), .glb_req_o(glb_req_o),
    .glb_addr_o(glb_addr_o), .glb_gnt_i(glb_gnt_i), .glb_rvalid_i(glb_rvalid_i),
    .glb_rdata_i(glb_rdata_i), .fifo_push_en_o(fifo_push_en_o),
    .fifo_push_mod_o(fifo_push_mod_o), .fifo_push_data_o(fifo_push_data_o),
    .fifo_full_i(fifo_full_i), .fifo_empty_i(fifo_empty_i), .fifo_reset_o(fifo_reset_o)
  );

  int checks = 0, errors = 0, cyc = 0;
  int fifo_cnt = 0, drain_mode = 1, gnt_pct = 100, gnt_block = 0, lat = 1, last_due = 0;
  int due_q[$];
  logic [31:0] dat_q[$];
  logic [7:0]  got_b[$];
  logic [31:0] got_a[$];
  int done_seen = 0;
  bit prev_wait = 0, last_done = 0;
  logic [31:0] prev_addr = '0;
  bit          drv_start = 0, drv_flush = 0;
  logic [31:0] drv_base = '0;
  logic [15:0] drv_cnt = '0;
  logic [1:0]  drv_pf = '0, drv_pb = '0;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
  endfunction

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic env_clear();
    due_q.delete(); dat_q.delete(); got_b.delete(); got_a.delete();
    fifo_cnt = 0; prev_wait = 0; last_done = 0; last_due = cyc;
  endtask

  // One clock: drive inputs at negedge, sample #1 later, update the models.
  task automatic cycle();
    int d;
    logic [31:0] w;
    @(negedge clk);
    cyc++;
    start_i = drv_start; flush_i = drv_flush;
    base_addr_i = drv_base; word_cnt_i = drv_cnt; pad_front_i = drv_pf; pad_back_i = drv_pb;
    if (gnt_block > 0) begin glb_gnt_i = 1'b0; gnt_block--; end
    else glb_gnt_i = (int'($urandom_range(0, 99)) < gnt_pct);
    glb_rvalid_i = 1'b0; glb_rdata_i = $urandom;
    if (due_q.size() > 0 && due_q[0] == cyc) begin
      glb_rvalid_i = 1'b1; glb_rdata_i = dat_q[0];
      void'(due_q.pop_front()); void'(dat_q.pop_front());
    end
    fifo_empty_i = (fifo_cnt == 0);
    fifo_full_i  = (fifo_cnt >= CAP);
    #1;
    if (last_done) chk1("busy_after_done", busy_o, 1'b0);
    last_done = done_o;
    if (done_o) done_seen++;
    if (prev_wait && !flush_i) begin
      chk1("req_held", glb_req_o, 1'b1);
      chk32("addr_held", glb_addr_o, prev_addr);
    end
    prev_wait = glb_req_o && !glb_gnt_i;
    prev_addr = glb_addr_o;
    if (flush_i) begin
      chk1("flush_fifo_reset", fifo_reset_o, 1'b1);
      chk1("flush_push", fifo_push_en_o, 1'b0);
      chk1("flush_req", glb_req_o, 1'b0);
      chk1("flush_done", done_o, 1'b0);
    end
    if (fifo_push_en_o) begin
      if (fifo_push_mod_o) begin
        chk1("burst_only_empty", fifo_empty_i, 1'b1);
        w = fifo_push_data_o;
        for (int k = 0; k < 4; k++) got_b.push_back(w[8*k +: 8]);
        fifo_cnt += 4;
      end else begin
        chk1("byte_only_not_full", fifo_full_i, 1'b0);
        got_b.push_back(fifo_push_data_o[7:0]);
        fifo_cnt++;
      end
    end
    if (glb_req_o && glb_gnt_i) begin
      got_a.push_back(glb_addr_o);
      d = cyc + lat;
      if (d <= last_due) d = last_due + 1;
      due_q.push_back(d); dat_q.push_back(mem(glb_addr_o)); last_due = d;
    end
    if (fifo_reset_o) begin fifo_cnt = 0; got_b.delete(); got_a.delete(); end
    if (drain_mode == 2) fifo_cnt = 0;
    else if (drain_mode == 1 && fifo_cnt > 0 && $urandom_range(0, 1) == 1) fifo_cnt--;
  endtask

  task automatic launch(input logic [31:0] b, input logic [15:0] c, input logic [1:0] f, input logic [1:0] p);
    drv_base = b; drv_cnt = c; drv_pf = f; drv_pb = p; drv_start = 1;
    cycle();
    drv_start = 0;
  endtask

  task automatic wait_done(input string tag, input int d0);
    int n = 0;
    while (done_seen == d0 && n < 3000) begin cycle(); n++; end
    chk32({tag, "_done_count"}, 32'(done_seen - d0), 32'd1);
  endtask

  task automatic run_job(input string tag, input logic [31:0] b, input logic [15:0] c,
                         input logic [1:0] f, input logic [1:0] p, input bit spurious);
    logic [7:0]  eb[$];
    logic [31:0] ea[$];
    logic [31:0] m;
    int d0, n;
    for (int i = 0; i < int'(f); i++) eb.push_back(8'h00);
    for (int i = 0; i < int'(c); i++) begin
      ea.push_back(b + 32'(4 * i));
      m = mem(b + 32'(4 * i));
      for (int k = 0; k < 4; k++) eb.push_back(m[8*k +: 8]);
    end
    for (int i = 0; i < int'(p); i++) eb.push_back(8'h00);
    got_b.delete(); got_a.delete();
    d0 = done_seen;
    launch(b, c, f, p);
    n = 0;
    while (done_seen == d0 && n < 3000) begin
      if (spurious && n == 2) begin
        drv_base = 32'hDEAD_0000; drv_cnt = 16'd7; drv_pf = 2'd3; drv_pb = 2'd3; drv_start = 1;
      end else drv_start = 0;
      cycle(); n++;
    end
    drv_start = 0;
    chk32({tag, "_done_count"}, 32'(done_seen - d0), 32'd1);
    cycle();
    chk32({tag, "_byte_count"}, 32'(got_b.size()), 32'(eb.size()));
    for (int i = 0; i < eb.size() && i < got_b.size(); i++)
      chk32({tag, "_byte"}, 32'(got_b[i]), 32'(eb[i]));
    chk32({tag, "_req_count"}, 32'(got_a.size()), 32'(ea.size()));
    for (int i = 0; i < ea.size() && i < got_a.size(); i++)
      chk32({tag, "_req_addr"}, got_a[i], ea[i]);
  endtask

  task automatic check_all_zero(input string tag);
    chk1({tag, "_busy"}, busy_o, 1'b0);
    chk1({tag, "_done"}, done_o, 1'b0);
    chk1({tag, "_req"}, glb_req_o, 1'b0);
    chk32({tag, "_addr"}, glb_addr_o, 32'd0);
    chk1({tag, "_push_en"}, fifo_push_en_o, 1'b0);
    chk1({tag, "_push_mod"}, fifo_push_mod_o, 1'b0);
    chk32({tag, "_push_data"}, fifo_push_data_o, 32'd0);
    chk1({tag, "_fifo_reset"}, fifo_reset_o, 1'b0);
  endtask

  initial begin
    logic [31:0] m;
    int d0, n;
    #1;
    check_all_zero("reset");
    env_clear();
    cycle(); cycle();
    #1 rst_n = 1'b1;
    d0 = done_seen;
    for (int i = 0; i < 4; i++) cycle();
    chk32("post_reset_pushes", 32'(got_b.size()), 32'd0);
    chk32("post_reset_reqs", 32'(got_a.size()), 32'd0);
    chk32("post_reset_done", 32'(done_seen - d0), 32'd0);

    // two words, immediate grant, data one cycle later, FIFO fully drained
    drain_mode = 2; gnt_pct = 100; lat = 1;
    run_job("basic", 32'h0000_0100, 16'd2, 2'd0, 2'd0, 1'b0);

    // front/back padding with slow random drain
    drain_mode = 1;
    run_job("pads", 32'h0000_0040, 16'd1, 2'd2, 2'd1, 1'b0);

    // grant held off five cycles, spurious start while busy
    gnt_block = 6;
    run_job("gnt_delay", 32'h0000_0800, 16'd2, 2'd0, 2'd1, 1'b1);

    // burst blocked while the FIFO holds a pad byte
    drain_mode = 0; gnt_pct = 100; lat = 1;
    got_b.delete(); d0 = done_seen;
    m = mem(32'h0000_0500);
    launch(32'h0000_0500, 16'd1, 2'd1, 2'd0);
    for (int i = 0; i < 4; i++) cycle();
    for (int i = 0; i < 10; i++) begin
      cycle();
      chk1("hold_no_push", fifo_push_en_o, 1'b0);
      chk32("hold_data_stable", fifo_push_data_o, m);
    end
    fifo_cnt = 0;
    cycle();
    chk1("hold_release_push", fifo_push_en_o, 1'b1);
    chk1("hold_release_mod", fifo_push_mod_o, 1'b1);
    chk32("hold_release_data", fifo_push_data_o, m);
    drain_mode = 1;
    wait_done("hold", d0);
    chk32("hold_byte_count", 32'(got_b.size()), 32'd5);

    // flush while a read is outstanding, stale data arrives late
    drain_mode = 1; lat = 8;
    got_b.delete(); got_a.delete();
    launch(32'h0000_0300, 16'd2, 2'd0, 2'd0);
    n = 0;
    while (got_a.size() == 0 && n < 100) begin cycle(); n++; end
    chk32("flush_grant_seen", 32'(got_a.size()), 32'd1);
    cycle();
    drv_flush = 1; cycle(); drv_flush = 0;
    cycle();
    chk1("flush_busy_cleared", busy_o, 1'b0);
    lat = 1;
    run_job("after_flush", 32'h0000_0200, 16'd2, 2'd0, 2'd0, 1'b0);
    chk32("after_flush_no_pending", 32'(due_q.size()), 32'd0);

    // randomized jobs, the first one wrapping the address space
    for (int j = 0; j < 10; j++) begin
      gnt_pct = int'($urandom_range(30, 100));
      lat = int'($urandom_range(1, 3));
      if (j == 0) run_job("wrap", 32'hFFFF_FFF8, 16'd4, 2'd1, 2'd1, 1'b0);
      else run_job("rand", $urandom & 32'hFFFF_FFFC, 16'($urandom_range(0, 5)),
                   2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 1'b0);
    end

    // asynchronous reset while parked in PUSH
    drain_mode = 0; gnt_pct = 100; lat = 1;
    launch(32'h0000_0700, 16'd1, 2'd1, 2'd0);
    for (int i = 0; i < 6; i++) cycle();
    chk1("pre_reset_in_push", fifo_push_mod_o, 1'b1);
    rst_n = 1'b0;
    #1;
    check_all_zero("mid_reset");
    env_clear();
    cycle(); cycle();
    #1 rst_n = 1'b1;
    drain_mode = 2;
    d0 = done_seen;
    for (int i = 0; i < 4; i++) cycle();
    chk32("rerelease_pushes", 32'(got_b.size()), 32'd0);
    chk32("rerelease_reqs", 32'(got_a.size()), 32'd0);
    chk32("rerelease_done", 32'(done_seen - d0), 32'd0);

    // empty job: done the cycle right after start, idle the next
    launch(32'h0000_0000, 16'd0, 2'd0, 2'd0);
    cycle();
    chk1("empty_job_done", done_o, 1'b1);
    chk1("empty_job_busy", busy_o, 1'b1);
    cycle();
    chk1("empty_job_done_once", done_o, 1'b0);
    chk1("empty_job_idle", busy_o, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
